// File: rtl/uart_tx.sv
// uart_tx: serial transmit half of the UART.
//
// Accepts a parallel byte with a one-cycle valid strobe while idle and shifts
// out one asynchronous frame: start bit (0), DATA_WIDTH data bits LSB first,
// optional parity bit, stop bit (1). Runs on the baud clock, one clk per bit.
//
// Ports:
//   clk        transmit bit clock, one cycle per serial bit
//   rst        asynchronous, active-low reset
//   p_data     parallel payload, sampled only on the accepting edge
//   data_valid request to send p_data, honoured only in idle
//   par_en     1 inserts a parity bit, sampled on the accepting edge
//   par_typ    0 even parity, 1 odd parity, sampled on the accepting edge
//   tx_out     serial line, idles high (registered)
//   busy       high while a frame is in progress (registered)

module uart_tx #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  parity_q, parity_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  // Outputs are registered: the next-state logic computes the line level that
  // the state being entered must drive, so tx_out and busy change on the same
  // edge as the state does.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    par_en_d = par_en_q;
    parity_d = parity_q;
    tx_d     = tx_q;
    busy_d   = busy_q;

    unique case (state_q)
      StIdle: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        cnt_d  = '0;
        if (data_valid) begin
          state_d  = StStart;
          data_d   = p_data;
          par_en_d = par_en;
          // Parity of the payload being latched; odd parity inverts it.
          parity_d = (^p_data) ^ par_typ;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
        end
      end

      StStart: begin
        state_d = StData;
        cnt_d   = '0;
        tx_d    = data_q[0];
        busy_d  = 1'b1;
      end

      StData: begin
        busy_d = 1'b1;
        if (cnt_q == CntLast) begin
          if (par_en_q) begin
            state_d = StParity;
            tx_d    = parity_q;
          end else begin
            state_d = StStop;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
          tx_d  = data_q[cnt_d];
        end
      end

      StParity: begin
        state_d = StStop;
        tx_d    = 1'b1;
        busy_d  = 1'b1;
      end

      StStop: begin
        // Return to idle; the next request is only seen from idle, which
        // guarantees at least one idle-high cycle between frames.
        state_d = StIdle;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      data_q   <= '0;
      par_en_q <= 1'b0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      par_en_q <= par_en_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

  assign tx_out = tx_q;
  assign busy   = busy_q;

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmit half of the UART: accepts a parallel byte with a one-cycle valid strobe and shifts out a complete asynchronous frame (start bit, data LSB-first, optional parity, stop bit) on a single line. It runs on the baud-rate clock, one `clk` cycle per bit, and pairs with the receive path. The receive path oversamples and votes; the transmitter needs no oversampling.

## Interface
- `DATA_WIDTH`, default 8: payload bits per frame.
- `clk` input 1: transmit bit clock, one cycle per serial bit.
- `rst` input 1: reset, asynchronous, active-low.
- `p_data` input `DATA_WIDTH`: parallel payload. Sampled only on the accepting edge.
- `data_valid` input 1: request to send `p_data`. Honoured only in IDLE.
- `par_en` input 1: 1 inserts a parity bit. Sampled on the accepting edge.
- `par_typ` input 1: 0 selects even parity, 1 selects odd. Sampled on the accepting edge.
- `tx_out` output 1: serial line. Idles high.
- `busy` output 1: high while a frame is in progress.

## Operation
- State machine with five states: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- Reset (asynchronous, any state): state goes to IDLE, `tx_out`=1, `busy`=0, bit counter=0, shift and config registers=0. Reset mid-frame aborts the frame immediately, with no partial stop bit.
- IDLE: `tx_out`=1, `busy`=0.
  - If `data_valid`=1 on an edge, latch `p_data`, `par_en` and `par_typ`.
  - Compute parity from the latched data: XOR of all bits, inverted when `par_typ`=1.
  - Go to START.
- START: drive `tx_out`=0, `busy`=1. Then go to DATA.
- DATA: drive latched bit[cnt], starting at cnt=0 (LSB first). cnt counts 0..`DATA_WIDTH`-1.
  - After the last data bit, go to PARITY if the latched `par_en`=1, else STOP.
- PARITY: drive the latched parity bit for one cycle, then go to STOP.
- STOP: drive `tx_out`=1 for one cycle, then go to IDLE with `busy`=0.
- `data_valid` outside IDLE is ignored. No queueing and no error flag.
- Changes on `p_data`, `par_en` or `par_typ` after acceptance do not affect the frame in flight.
- `data_valid` held high continuously sends repeated frames, each accepted in IDLE.
- Bit counter width is clog2(`DATA_WIDTH`). It resets to 0 on entry to DATA and never wraps mid-frame.

## Timing
- Let E0 be the edge where IDLE samples `data_valid`=1.
- After E0: `tx_out`=0 (start bit) and `busy`=1.
- After E0+k, for k=1..`DATA_WIDTH`: `tx_out` = data bit k-1.
- Without parity:
  - After E0+`DATA_WIDTH`+1: stop bit, `tx_out`=1.
  - After E0+`DATA_WIDTH`+2: IDLE, `busy`=0.
- With parity:
  - After E0+`DATA_WIDTH`+1: parity bit.
  - After E0+`DATA_WIDTH`+2: stop bit.
  - After E0+`DATA_WIDTH`+3: IDLE, `busy`=0.
- With `DATA_WIDTH`=8, `busy` is high for 10 cycles without parity and 11 with parity.
- The next frame can be accepted at the first edge after `busy` falls. This gives at least one idle-high cycle between frames, so the minimum frame pitch is 11 or 12 cycles.
- Start-bit latency from `data_valid` is one edge.
- `busy` rises on the same edge as the start bit and falls on the same edge the line returns to idle after the stop bit.

## Test plan
- Reset and idle: assert `rst`=0 mid-run, then release with `data_valid`=0 for 20 cycles -> `tx_out`=1 and `busy`=0 throughout.
- No parity: `p_data`=0xA5, `par_en`=0, one-cycle `data_valid` -> line sequence 0,1,0,1,0,0,1,0,1,1 one bit per cycle, `busy` high exactly 10 cycles, then `tx_out`=1.
- Even and odd parity: `p_data`=0x3C with `par_en`=1.
  - `par_typ`=0 -> parity bit 0, frame 0,0,0,1,1,1,1,0,0,0,1.
  - `par_typ`=1 -> parity bit 1. `busy` high 11 cycles in both cases.
- Input stability and ignored requests: change `p_data` to 0xFF and pulse `data_valid` during DATA -> frame still carries the originally latched byte, and no extra frame is sent.
- Back-to-back: hold `data_valid`=1 with 0x01, then 0x80 -> two complete frames separated by exactly one idle-high cycle, LSB-first order correct in each.
- Reset mid-frame: assert `rst` during data bit 4 -> `tx_out`=1 and `busy`=0 immediately, asynchronously. After release, a new 0x55 frame is transmitted correctly.
